// File: rtl/addsub_seq_if.sv
// Handshake and result bundle for the chunked sequential adder/subtractor.
// The issuing side is the master; the arithmetic unit is the slave.
interface addsub_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cf;
    logic             ovf;
    logic             sf;
    logic             zf;

    modport master (
        output start, a, b, sub,
        input  busy, done, sum, cf, ovf, sf, zf
    );

    modport slave (
        input  start, a, b, sub,
        output busy, done, sum, cf, ovf, sf, zf
    );
endinterface

// File: rtl/addsub_seq.sv
// Multi-cycle integer adder/subtractor: operands latched on start, CHUNK bits
// summed per cycle LSB-first through one narrow adder, flags registered at the end.
module addsub_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    addsub_seq_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              sub_r;
    logic              carry_r;
    logic [IDXW-1:0]   idx_r;
    logic [WIDTH-1:0]  acc_r;
    logic [WIDTH-1:0]  sum_r;
    logic              busy_r;
    logic              done_r;
    logic              cf_r;
    logic              ovf_r;
    logic              sf_r;
    logic              zf_r;

    int                base_s;
    logic [CHUNK-1:0]  a_chunk_s;
    logic [CHUNK-1:0]  b_chunk_s;
    logic [CHUNK-1:0]  s_chunk_s;
    logic              c_s;
    logic [WIDTH-1:0]  acc_next_s;
    logic              ovf_s;
    logic              accept_s;

    // One chunk of the ripple: subtraction is a + ~b with the carry preset to 1.
    always_comb begin
        base_s     = int'(idx_r) * CHUNK;
        a_chunk_s  = a_r[base_s +: CHUNK];
        b_chunk_s  = b_r[base_s +: CHUNK] ^ {CHUNK{sub_r}};
        {c_s, s_chunk_s} = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_r};
        acc_next_s = acc_r;
        acc_next_s[base_s +: CHUNK] = s_chunk_s;
        // Overflow when both effective operands share a sign the result does not.
        ovf_s      = (a_r[WIDTH-1] == (b_r[WIDTH-1] ^ sub_r)) &&
                     (acc_next_s[WIDTH-1] != a_r[WIDTH-1]);
        if (state_r != ST_RUN) begin
            accept_s = bus.start;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Control FSM, chunk datapath and registered result/flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            sub_r   <= 1'b0;
            carry_r <= 1'b0;
            idx_r   <= {IDXW{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cf_r    <= 1'b0;
            ovf_r   <= 1'b0;
            sf_r    <= 1'b0;
            zf_r    <= 1'b0;
        end else if (accept_s) begin
            state_r <= ST_RUN;
            a_r     <= bus.a;
            b_r     <= bus.b;
            sub_r   <= bus.sub;
            carry_r <= bus.sub;
            idx_r   <= {IDXW{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    acc_r   <= acc_next_s;
                    carry_r <= c_s;
                    if (idx_r == LAST_IDX) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        sum_r   <= acc_next_s;
                        cf_r    <= sub_r ? ~c_s : c_s;
                        ovf_r   <= ovf_s;
                        sf_r    <= acc_next_s[WIDTH-1];
                        zf_r    <= (acc_next_s == {WIDTH{1'b0}});
                    end else begin
                        idx_r   <= idx_r + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                ST_IDLE: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cf   = cf_r;
    assign bus.ovf  = ovf_r;
    assign bus.sf   = sf_r;
    assign bus.zf   = zf_r;
endmodule

// File: tb/tb_addsub_seq.sv
// Directed and random scoreboard bench for addsub_seq at WIDTH=32, CHUNK=8.
module tb_addsub_seq;
    localparam int W   = 32;
    localparam int LAT = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cf;
        logic         ovf;
        logic         sf;
        logic         zf;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    exp_t q[$];

    addsub_seq_if #(.WIDTH(W)) bus ();

    addsub_seq #(.WIDTH(W), .CHUNK(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t     e;
        logic [W:0] full;
        if (s) full = {1'b0, a} - {1'b0, b};
        else   full = {1'b0, a} + {1'b0, b};
        e.sum = full[W-1:0];
        e.cf  = full[W];
        e.sf  = full[W-1];
        e.zf  = (full[W-1:0] == '0);
        if (s) e.ovf = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
        else   e.ovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request so that it is sampled on the next rising edge; returns #1 after it.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit push);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = s;
        if (push) q.push_back(model(a, b, s));
        @(posedge clk);
        #1;
        check("busy_after_start", {63'd0, bus.busy}, 64'd1);
        check("done_after_start", {63'd0, bus.done}, 64'd0);
        bus.start = 1'b0;
    endtask

    task automatic finish_op(input int exp_lat);
        int   cyc;
        bit   seen;
        exp_t e;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check("latency", 64'(cyc), 64'(exp_lat));
        if (q.size() > 0) e = q.pop_front();
        else              e = '0;
        check("sum", 64'(bus.sum), 64'(e.sum));
        check("cf",  {63'd0, bus.cf},  {63'd0, e.cf});
        check("ovf", {63'd0, bus.ovf}, {63'd0, e.ovf});
        check("sf",  {63'd0, bus.sf},  {63'd0, e.sf});
        check("zf",  {63'd0, bus.zf},  {63'd0, e.zf});
        check("busy_at_done", {63'd0, bus.busy}, 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
        check({tag, "_done"}, {63'd0, bus.done}, 64'd0);
        check({tag, "_sum"},  64'(bus.sum), 64'd0);
        check({tag, "_flags"}, {60'd0, bus.cf, bus.ovf, bus.sf, bus.zf}, 64'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb, held;
        bit           saw_done;
        n_vec     = 0;
        n_err     = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.sub   = 1'b0;
        #12;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed arithmetic corners, with literal expectations for the headline case.
        launch(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        finish_op(LAT);
        check("ovf_case_sum", 64'(bus.sum), 64'h8000_0000);
        check("ovf_case_ovf", {63'd0, bus.ovf}, 64'd1);
        launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);  finish_op(LAT);
        launch(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1);  finish_op(LAT);
        check("ripple_sum", 64'(bus.sum), 64'h0000_0100);
        launch(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1);  finish_op(LAT);
        launch(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1);  finish_op(LAT);
        check("sub_neg_sum", 64'(bus.sum), 64'hFFFF_FFFE);
        launch(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);  finish_op(LAT);
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);  finish_op(LAT);

        // Without a new start, done drops after one cycle.
        @(posedge clk);
        #1;
        check("done_pulse_width", {63'd0, bus.done}, 64'd0);

        // Reset in the middle of an operation: cleared at once, no done afterwards.
        launch(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_state("midrun_reset");
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        check("no_done_after_abort", {63'd0, saw_done}, 64'd0);
        launch(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1);  finish_op(LAT);

        // Start during RUN with other operands is ignored.
        launch(32'h0000_1000, 32'h0000_0234, 1'b1, 1'b1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h0BAD_F00D;
        bus.sub   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        finish_op(LAT - 1);

        // Start during DONE: previous result held until the next completion.
        launch(32'h0000_0042, 32'h0000_0001, 1'b0, 1'b1);
        finish_op(LAT);
        held = bus.sum;
        launch(32'h0000_0100, 32'h0000_0200, 1'b1, 1'b1);
        check("sum_held_during_run", 64'(bus.sum), 64'(held));
        finish_op(LAT);

        // Random operands with a bias toward sign/carry corners.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: ra = 32'h7FFF_FFFF;
                2: ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'h0000_0001;
                1: rb = 32'h8000_0000;
                2: rb = ra;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) repeat (2) @(posedge clk);
            launch(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
            finish_op(LAT);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
